scr_ndim_core: RTL and testbench

//  Parallel, parametrised LFSR scrambler/descrambler. Processes DATA_WIDTH bits per beat.

---
 rtl/scr_ndim_core.sv | 89 ++++++++
 tb/tb_scr_ndim_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/scr_ndim_core.sv
// scr_ndim_core: parallel LFSR scrambler/descrambler, additive or multiplicative, DATA_WIDTH bits per beat.
// Optional per-frame LFSR reload and frame_start output enabled by defining SCR_FRAME_RESYNC_EN.
module scr_ndim_core #(
  parameter int                   DATA_WIDTH   = 8,
  parameter int                   SCR_WIDTH    = 7,
  parameter logic [SCR_WIDTH-1:0] POLY         = 7'h60,
  parameter logic [SCR_WIDTH-1:0] INIT_DEFAULT = 7'h7F,
  parameter int                   FRAME_LEN    = 1024
) (
  input  logic                  clk,
  input  logic                  kill_n,
  input  logic                  scr_en,
  input  logic                  mode,
  input  logic                  descr,
  input  logic [SCR_WIDTH-1:0]  init_val,
  input  logic                  init_val_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_en,
  output logic                  data_in_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_en,
  input  logic                  data_out_rdy
`ifdef SCR_FRAME_RESYNC_EN
  ,
  output logic                  frame_start
`endif
);
  logic [SCR_WIDTH-1:0]  s, s_start, s_step;
  logic [DATA_WIDTH-1:0] o;
  logic                  acc;

  assign data_in_rdy = !data_out_en || data_out_rdy;
  assign acc         = data_in_en && data_in_rdy;

`ifdef SCR_FRAME_RESYNC_EN
  localparam int CW = $clog2(FRAME_LEN + 1);
  logic [CW-1:0] cnt, cnt_base;
  logic          first;

  // A same-cycle load restarts the frame, so the loaded value wins over INIT_DEFAULT
  assign cnt_base = init_val_en ? '0 : cnt;
  assign first    = cnt_base == '0;
  assign s_start  = init_val_en ? init_val : first ? INIT_DEFAULT : s;

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      if (acc && scr_en) cnt <= (cnt_base == CW'(FRAME_LEN - 1)) ? '0 : cnt_base + 1'b1;
      else cnt <= cnt_base;
      if (acc) frame_start <= scr_en && first;
    end
  end
`else
  assign s_start = init_val_en ? init_val : s;
`endif

  always_comb begin
    logic [SCR_WIDTH-1:0] st;
    logic                 f;
    st = s_start;
    o  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      f    = ^(st & POLY);
      o[i] = data_in[i] ^ f;
      st   = {st[SCR_WIDTH-2:0], mode ? (descr ? data_in[i] : o[i]) : f};
    end
    s_step = st;
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) s <= INIT_DEFAULT;
    else if (acc && scr_en) s <= s_step;
    else if (init_val_en) s <= init_val;
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      data_out    <= '0;
      data_out_en <= 1'b0;
    end else if (acc) begin
      data_out    <= scr_en ? o : data_in;
      data_out_en <= 1'b1;
    end else if (data_out_rdy) begin
      data_out_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_scr_ndim_core.sv
// tb_scr_ndim_core: directed vector table plus handshake, reset and scrambler-to-descrambler sequences.
module tb_scr_ndim_core;
  logic       clk = 1'b0;
  logic       kill_n = 1'b0;
  logic       scr_en = 1'b1, mode = 1'b0, descr = 1'b0;
  logic [6:0] init_val = '0;
  logic       init_val_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_in_en = 1'b0;
  logic       data_in_rdy;
  logic [7:0] data_out;
  logic       data_out_en;
  logic       data_out_rdy = 1'b1;
  logic [6:0] dsc_init = 7'h7F;
  logic       dsc_init_en = 1'b0;
  logic       dsc_in_rdy;
  logic [7:0] dsc_out;
  logic       dsc_en;
`ifdef SCR_FRAME_RESYNC_EN
  logic       frame_start, dsc_fs;
`endif

  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  scr_ndim_core #(.FRAME_LEN(4)) dut (
    .clk(clk), .kill_n(kill_n), .scr_en(scr_en), .mode(mode), .descr(descr),
    .init_val(init_val), .init_val_en(init_val_en), .data_in(data_in), .data_in_en(data_in_en),
    .data_in_rdy(data_in_rdy), .data_out(data_out), .data_out_en(data_out_en), .data_out_rdy(data_out_rdy)
`ifdef SCR_FRAME_RESYNC_EN
    , .frame_start(frame_start)
`endif
  );

  scr_ndim_core #(.FRAME_LEN(4)) u_dsc (
    .clk(clk), .kill_n(kill_n), .scr_en(1'b1), .mode(1'b1), .descr(1'b1),
    .init_val(dsc_init), .init_val_en(dsc_init_en), .data_in(data_out),
    .data_in_en(data_out_en && data_out_rdy), .data_in_rdy(dsc_in_rdy),
    .data_out(dsc_out), .data_out_en(dsc_en), .data_out_rdy(1'b1)
`ifdef SCR_FRAME_RESYNC_EN
    , .frame_start(dsc_fs)
`endif
  );

  typedef struct {
    logic       sen, md, ds, ie;
    logic [6:0] iv;
    logic [7:0] din, exp;
  } vec_t;
  vec_t vt[12];

  logic [7:0] src[64];
  logic [7:0] rx[$];
  logic       collect = 1'b0;

  always @(negedge clk) if (collect && dsc_en) rx.push_back(dsc_out);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_chain(input logic [6:0] di, input int first_chk);
    data_in_en = 1'b0;
    repeat (3) tick();
    rx.delete();
    collect = 1'b1;
    scr_en = 1'b1; mode = 1'b1; descr = 1'b0; data_out_rdy = 1'b1;
    for (int k = 0; k < 64; k++) begin
      src[k]      = 8'($urandom);
      data_in     = src[k];
      data_in_en  = 1'b1;
      init_val    = 7'h7F;
      init_val_en = (k == 0);
      dsc_init    = di;
      dsc_init_en = (k == 0);
      tick();
    end
    data_in_en = 1'b0; init_val_en = 1'b0; dsc_init_en = 1'b0;
    repeat (4) tick();
    collect = 1'b0;
    chk("chain_count", rx.size(), 64);
    for (int k = first_chk; k < 64 && k < rx.size(); k++) chk($sformatf("chain_beat%0d", k), rx[k], src[k]);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'h00, 8'hA5, 8'hA5};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 8'h3C, 8'h3C};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'h7F, 8'h00, 8'h40};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h3C, 8'h3C};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'hC3, 8'hC3};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h30};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'h7F, 8'hFF, 8'hBF};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 7'h7F, 8'h00, 8'h40};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 8'h30};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'h7F, 8'h00, 8'h40};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'h00, 8'h00, 8'h00};
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'h7F, 8'hFF, 8'hFF};

    repeat (2) tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_out_en", data_out_en, 0);
    chk("rst_in_rdy", data_in_rdy, 1);
`ifdef SCR_FRAME_RESYNC_EN
    chk("rst_frame_start", frame_start, 0);
`endif
    kill_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      scr_en = vt[i].sen; mode = vt[i].md; descr = vt[i].ds;
      init_val_en = vt[i].ie; init_val = vt[i].iv;
      data_in = vt[i].din; data_in_en = 1'b1;
      tick();
      chk($sformatf("vec%0d_data", i), data_out, vt[i].exp);
      chk($sformatf("vec%0d_en", i), data_out_en, 1);
    end
    data_in_en = 1'b0; init_val_en = 1'b0;
    tick();
    chk("idle_en", data_out_en, 0);

    // load without a beat, then scramble from the loaded value
    scr_en = 1'b1; mode = 1'b0;
    init_val = 7'h7F; init_val_en = 1'b1;
    tick();
    chk("load_no_out", data_out_en, 0);
    init_val_en = 1'b0; data_in = 8'h00; data_in_en = 1'b1;
    tick();
    chk("load_then_beat", data_out, 8'h40);

    // backpressure in bypass
    scr_en = 1'b0; data_in = 8'h11;
    tick();
    chk("bp_first", data_out, 8'h11);
    data_out_rdy = 1'b0; data_in = 8'h22;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_rdy%0d", c), data_in_rdy, 0);
      chk($sformatf("bp_hold%0d", c), data_out, 8'h11);
      chk($sformatf("bp_en%0d", c), data_out_en, 1);
    end
    data_out_rdy = 1'b1;
    #1 chk("bp_release_rdy", data_in_rdy, 1);
    tick();
    chk("bp_second", data_out, 8'h22);
    data_in_en = 1'b0;
    tick();
    chk("bp_no_dup", data_out_en, 0);

    run_chain(7'h7F, 0);
    run_chain(7'h11, 1);

    // asynchronous kill mid-stream
    scr_en = 1'b1; mode = 1'b0; data_in = 8'h5A; data_in_en = 1'b1;
    tick();
    chk("pre_kill_en", data_out_en, 1);
    kill_n = 1'b0; data_in_en = 1'b0;
    #1;
    chk("kill_en", data_out_en, 0);
    chk("kill_data", data_out, 0);
    tick();
    kill_n = 1'b1;
    data_in = 8'h00; data_in_en = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      tick();
      if (b == 1) chk("post_kill_beat1", data_out, 8'h40);
      if (b == 2) chk("post_kill_beat2", data_out, 8'h30);
`ifdef SCR_FRAME_RESYNC_EN
      chk($sformatf("frame_start_beat%0d", b), frame_start, (b == 1 || b == 5));
      if (b == 5) chk("post_kill_beat5", data_out, 8'h40);
`endif
    end
    data_in_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
